// File: rtl/tx_sequencer_if.sv
// Request and byte-slot control bundle between protocol controller,
// tx_sequencer and the TX byte selector / serializer.
interface tx_sequencer_if;
  logic       tx_packet_valid;
  logic [3:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic       sync_start;
  logic       pid_start;
  logic       crc_start;
  logic       load_byte;
  logic       get_tx_packet_data;
  logic       eop;
  logic       tx_active;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_packet_valid,
    output tx_packet,
    output buffer_occupancy,
    input  sync_start,
    input  pid_start,
    input  crc_start,
    input  load_byte,
    input  get_tx_packet_data,
    input  eop,
    input  tx_active,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_packet_valid,
    input  tx_packet,
    input  buffer_occupancy,
    output sync_start,
    output pid_start,
    output crc_start,
    output load_byte,
    output get_tx_packet_data,
    output eop,
    output tx_active,
    output tx_done,
    output tx_error
  );
endinterface

// File: rtl/tx_sequencer.sv
// USB FS transmit sequencer: SYNC/PID/DATA/CRC/EOP byte-slot control.
// Optional bit-stuff stretching when TX_SEQ_STUFF_EN is defined.
module tx_sequencer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64
) (
  input logic clk,
  input logic n_rst,
`ifdef TX_SEQ_STUFF_EN
  input logic stuff_bit,
`endif
  tx_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRC1,
    S_CRC2,
    S_EOP,
    S_IDLE_J
  } state_t;

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [6:0] MAXB = 7'(MAX_BYTES);

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA  = 4'b0011;

  state_t        state, state_n;
  logic [CW-1:0] clk_cnt, clk_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [6:0]    byte_cnt, byte_n;
  logic [3:0]    pid_q, pid_n;
  logic          rpt, rpt_n;

  logic bit_end;
  logic slot_st;
  logic stuff_hit;
  logic hs_pid;
  logic req_ok;
  logic req_bad;
  logic [6:0] occ_clamp;

  logic sync_d, pid_d, crc_d, load_d;
  logic pop_d, eop_d, act_d, done_d, err_d;
  logic sync_q, pid_q_o, crc_q, load_q;
  logic pop_q, eop_q, act_q, done_q, err_q;

  assign bit_end = (clk_cnt == CLK_LAST);
  assign slot_st = (state == S_SYNC) ||
                   (state == S_PID)  ||
                   (state == S_DATA) ||
                   (state == S_CRC1) ||
                   (state == S_CRC2);

`ifdef TX_SEQ_STUFF_EN
  assign stuff_hit = stuff_bit && slot_st;
`else
  assign stuff_hit = 1'b0;
`endif

  assign hs_pid = (bus.tx_packet == PID_ACK)   ||
                  (bus.tx_packet == PID_NAK)   ||
                  (bus.tx_packet == PID_STALL) ||
                  (bus.tx_packet == PID_DATA);

  assign req_ok  = (state == S_IDLE) &&
                   bus.tx_packet_valid && hs_pid;
  assign req_bad = (state == S_IDLE) &&
                   bus.tx_packet_valid && !hs_pid;

  assign occ_clamp = (bus.buffer_occupancy > MAXB) ?
                     MAXB : bus.buffer_occupancy;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      pid_q    <= '0;
      rpt      <= 1'b0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      pid_q    <= pid_n;
      rpt      <= rpt_n;
    end
  end

  always_comb begin
    state_n = state;
    clk_n   = clk_cnt;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    pid_n   = pid_q;
    rpt_n   = rpt;
    if (state == S_IDLE) begin
      clk_n = '0;
      bit_n = '0;
      rpt_n = 1'b0;
      if (req_ok) begin
        state_n = S_SYNC;
        pid_n   = bus.tx_packet;
        byte_n  = occ_clamp;
      end
    end else begin
      clk_n = bit_end ? '0 : clk_cnt + 1'b1;
      if (bit_end) begin
        // a stuffed bit repeats the current bit time
        rpt_n = stuff_hit;
        if (!stuff_hit) begin
          bit_n = bit_cnt + 3'd1;
          unique case (state)
            S_SYNC:
              if (bit_cnt == 3'd7) state_n = S_PID;
            S_PID:
              if (bit_cnt == 3'd7) begin
                if (pid_q != PID_DATA)
                  state_n = S_EOP;
                else if (byte_cnt != 7'd0)
                  state_n = S_DATA;
                else
                  state_n = S_CRC1;
              end
            S_DATA:
              if (bit_cnt == 3'd7) begin
                byte_n  = byte_cnt - 7'd1;
                state_n = (byte_cnt > 7'd1) ?
                          S_DATA : S_CRC1;
              end
            S_CRC1:
              if (bit_cnt == 3'd7) state_n = S_CRC2;
            S_CRC2:
              if (bit_cnt == 3'd7) state_n = S_EOP;
            S_EOP:
              if (bit_cnt == 3'd1) begin
                state_n = S_IDLE_J;
                bit_n   = '0;
              end
            S_IDLE_J: begin
              state_n = S_IDLE;
              bit_n   = '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // decode from next-state values so every output is a flop
  always_comb begin
    sync_d = (state_n == S_SYNC);
    pid_d  = (state_n == S_PID);
    crc_d  = (state_n == S_CRC1) || (state_n == S_CRC2);
    eop_d  = (state_n == S_EOP);
    act_d  = (state_n != S_IDLE);
    load_d = ((state_n == S_SYNC) ||
              (state_n == S_PID)  ||
              (state_n == S_DATA) ||
              crc_d) &&
             (clk_n == '0) && (bit_n == 3'd0) && !rpt_n;
    pop_d  = (state_n == S_DATA) &&
             (clk_n == CLK_LAST) && (bit_n == 3'd7) &&
             !rpt_n;
    done_d = (state == S_IDLE_J) && (state_n == S_IDLE);
    err_d  = req_bad;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q  <= 1'b0;
      pid_q_o <= 1'b0;
      crc_q   <= 1'b0;
      load_q  <= 1'b0;
      pop_q   <= 1'b0;
      eop_q   <= 1'b0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      pid_q_o <= pid_d;
      crc_q   <= crc_d;
      load_q  <= load_d;
      pop_q   <= pop_d;
      eop_q   <= eop_d;
      act_q   <= act_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.sync_start         = sync_q;
  assign bus.pid_start          = pid_q_o;
  assign bus.crc_start          = crc_q;
  assign bus.load_byte          = load_q;
  assign bus.get_tx_packet_data = pop_q;
  assign bus.eop                = eop_q;
  assign bus.tx_active          = act_q;
  assign bus.tx_done            = done_q;
  assign bus.tx_error           = err_q;

endmodule
